// File: rtl/rc5_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rc5_core_param                                               |
// | Description : Iterative RC5-W/R/b block cipher engine, one round per       |
// |               clock, runtime-loadable subkey table, valid/ready request    |
// |               and result handshakes.                                       |
// | Options     : RC5_ABORT_EN adds an abort input that cancels an operation   |
// |               in flight.                                                   |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module rc5_core_param #(
  parameter int W          = 16,
  parameter int MAX_ROUNDS = 16,
  parameter int RW         = $clog2(MAX_ROUNDS + 1),
  parameter int AW         = $clog2(2 * MAX_ROUNDS + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic            mode,
  input  logic [RW-1:0]   rounds,
  input  logic [2*W-1:0]  d_in,
  input  logic            skey_we,
  input  logic [AW-1:0]   skey_addr,
  input  logic [W-1:0]    skey_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  d_out,
`ifdef RC5_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy
);

  localparam int DEPTH = 2 * MAX_ROUNDS + 2;
  localparam int SW    = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_POSTW = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [RW-1:0]   i_q, i_d, r_q, r_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    skey_q [DEPTH];

  logic [RW-1:0]   w_r_sat;
  logic [AW-1:0]   w_idx_e, w_idx_o;
  logic [W-1:0]    w_enc_a, w_enc_b, w_dec_a, w_dec_b;

  // Rotation by the low log2(W) bits: take the matching half of a doubled word.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SW-1:0] s);
    logic [2*W-1:0] t;
    t = {x, x} << s;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [SW-1:0] s);
    logic [2*W-1:0] t;
    t = {x, x} >> s;
    return t[W-1:0];
  endfunction

  // Requested round counts beyond the table size are clamped.
  assign w_r_sat = (rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : rounds;

  // Round i uses the subkey pair S[2i], S[2i+1].
  assign w_idx_e = AW'({i_q, 1'b0});
  assign w_idx_o = w_idx_e | AW'(1);

  assign w_enc_a = rotl(a_q ^ b_q, b_q[SW-1:0]) + skey_q[w_idx_e];
  assign w_enc_b = rotl(b_q ^ w_enc_a, w_enc_a[SW-1:0]) + skey_q[w_idx_o];
  assign w_dec_b = rotr(b_q - skey_q[w_idx_o], a_q[SW-1:0]) ^ a_q;
  assign w_dec_a = rotr(a_q - skey_q[w_idx_e], w_dec_b[SW-1:0]) ^ w_dec_b;

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign d_out       = (state_q == S_DONE) ? {b_q, a_q} : '0;

  // Subkey table: writable only while idle, out-of-range indexes dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        skey_q[k] <= '0;
      end
    end else if ((state_q == S_IDLE) && skey_we && (int'(skey_addr) < DEPTH)) begin
      skey_q[skey_addr] <= skey_wdata;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath update for one round per cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    r_d     = r_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          mode_d = mode;
          r_d    = w_r_sat;
          if (!mode) begin
            a_d     = d_in[W-1:0] + skey_q[0];
            b_d     = d_in[2*W-1:W] + skey_q[1];
            i_d     = RW'(1);
            state_d = (w_r_sat != '0) ? S_ROUND : S_DONE;
          end else begin
            a_d     = d_in[W-1:0];
            b_d     = d_in[2*W-1:W];
            i_d     = w_r_sat;
            state_d = (w_r_sat != '0) ? S_ROUND : S_POSTW;
          end
        end
      end
      S_ROUND: begin
        if (!mode_q) begin
          a_d = w_enc_a;
          b_d = w_enc_b;
          if (i_q == r_q) begin
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          a_d = w_dec_a;
          b_d = w_dec_b;
          if (i_q == RW'(1)) begin
            state_d = S_POSTW;
          end else begin
            i_d = i_q - 1'b1;
          end
        end
      end
      S_POSTW: begin
        b_d     = b_q - skey_q[1];
        a_d     = a_q - skey_q[0];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef RC5_ABORT_EN
    // Abort discards the working block; the subkey table is untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rc5_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rc5_core_param                                            |
// | Description : Self-checking bench for rc5_core_param: vector table,        |
// |               expected-result queue, reference cipher model.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rc5_core_param;

  localparam int W  = 16;
  localparam int MR = 16;
  localparam int RW = $clog2(MR + 1);
  localparam int AW = $clog2(2 * MR + 2);
  localparam int NK = 2 * MR + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_valid;
  logic            start_ready;
  logic            mode;
  logic [RW-1:0]   rounds;
  logic [2*W-1:0]  d_in;
  logic            skey_we;
  logic [AW-1:0]   skey_addr;
  logic [W-1:0]    skey_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  d_out;
  logic            busy;
  logic            abort;

  rc5_core_param #(.W(W), .MAX_ROUNDS(MR)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mode        (mode),
    .rounds      (rounds),
    .d_in        (d_in),
    .skey_we     (skey_we),
    .skey_addr   (skey_addr),
    .skey_wdata  (skey_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_out       (d_out),
`ifdef RC5_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0]   skm [NK];
  logic [2*W-1:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit             dec;
    int             r;
    logic [2*W-1:0] din;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t v0 [4];
  vec_t v1 [2];

  function automatic logic [W-1:0] rl(input logic [W-1:0] x, input int n);
    int m;
    m = n % W;
    if (m == 0) return x;
    return (x << m) | (x >> (W - m));
  endfunction

  function automatic logic [W-1:0] rr(input logic [W-1:0] x, input int n);
    int m;
    m = n % W;
    if (m == 0) return x;
    return (x >> m) | (x << (W - m));
  endfunction

  function automatic logic [2*W-1:0] ref_rc5(input bit dec, input int r, input logic [2*W-1:0] blk);
    logic [W-1:0] a, b;
    int rr_n;
    rr_n = (r > MR) ? MR : r;
    a = blk[W-1:0];
    b = blk[2*W-1:W];
    if (!dec) begin
      a = a + skm[0];
      b = b + skm[1];
      for (int i = 1; i <= rr_n; i++) begin
        a = rl(a ^ b, int'(b)) + skm[2*i];
        b = rl(b ^ a, int'(a)) + skm[2*i+1];
      end
    end else begin
      for (int i = rr_n; i >= 1; i--) begin
        b = rr(b - skm[2*i+1], int'(a)) ^ a;
        a = rr(a - skm[2*i], int'(b)) ^ b;
      end
      b = b - skm[1];
      a = a - skm[0];
    end
    return {b, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input int a, input logic [W-1:0] v);
    skey_we    = 1'b1;
    skey_addr  = AW'(a);
    skey_wdata = v;
    step();
    skey_we = 1'b0;
    if (a < NK) skm[a] = v;
  endtask

  task automatic do_op(input bit dec, input int r, input logic [2*W-1:0] din,
                       input logic [2*W-1:0] exp, input int hold, input bit wr_busy,
                       output logic [2*W-1:0] res);
    int n, lat, reff;
    logic [2*W-1:0] e;
    reff = (r > MR) ? MR : r;
    n = 0;
    while (!start_ready && n < 50) begin
      step();
      n++;
    end
    start_valid = 1'b1;
    mode        = dec;
    rounds      = RW'(r);
    d_in        = din;
    sb.push_back(exp);
    step();
    start_valid = 1'b0;
    mode        = ~dec;
    rounds      = '1;
    d_in        = $urandom;
    chk("start_ready_low", start_ready, 0);
    if (wr_busy) begin
      skey_we    = 1'b1;
      skey_addr  = AW'(2);
      skey_wdata = 16'hFFFF;
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      skey_we = 1'b0;
      lat++;
    end
    skey_we = 1'b0;
    chk("out_valid_seen", out_valid, 1);
    chk("latency", lat, dec ? reff + 2 : reff + 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        step();
        chk("hold_valid", out_valid, 1);
        chk("hold_dout", d_out, exp);
        chk("hold_start_ready", start_ready, 0);
      end
    end
    e = sb.pop_front();
    chk("d_out", d_out, e);
    res = d_out;
    out_ready = 1'b1;
    step();
    chk("after_handshake_flags", {out_valid, start_ready, busy}, 3'b010);
    chk("after_handshake_dout", d_out, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] res, blk, ce, blk2, e2;
    int seen;

    rst = 1'b0; start_valid = 1'b0; mode = 1'b0; rounds = '0; d_in = '0;
    skey_we = 1'b0; skey_addr = '0; skey_wdata = '0; out_ready = 1'b1; abort = 1'b0;
    for (int k = 0; k < NK; k++) skm[k] = '0;

    // Vector tables (subkeys all zero for v0; S[0]=5, S[1]=7 for v1).
    v0[0] = '{1'b0, 1, 32'h0001_0000, 32'h000C_0002};
    v0[1] = '{1'b1, 1, 32'h000C_0002, 32'h0001_0000};
    v0[2] = '{1'b0, 3, 32'hDEAD_BEEF, ref_rc5(1'b0, 3, 32'hDEAD_BEEF)};
    v0[3] = '{1'b1, 0, 32'h1234_5678, 32'h1234_5678};
    v1[0] = '{1'b0, 0, 32'h0010_0020, 32'h0017_0025};
    v1[1] = '{1'b1, 0, 32'h0017_0025, 32'h0010_0020};

    repeat (3) step();
    chk("reset_flags", {start_ready, out_valid, busy}, 3'b100);
    chk("reset_dout", d_out, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) do_op(v0[i].dec, v0[i].r, v0[i].din, v0[i].exp, 0, 1'b0, res);

    wr_key(0, 16'h0005);
    wr_key(1, 16'h0007);
    for (int i = 0; i < 2; i++) do_op(v1[i].dec, v1[i].r, v1[i].din, v1[i].exp, 0, 1'b0, res);

    // Random subkeys, full-length round trip with result backpressure.
    for (int k = 0; k < NK; k++) wr_key(k, W'($urandom));
    blk = $urandom;
    ce  = ref_rc5(1'b0, 16, blk);
    do_op(1'b0, 16, blk, ce, 5, 1'b0, res);
    do_op(1'b1, 16, res, blk, 0, 1'b0, res);
    // Oversized round count clamps to the maximum.
    do_op(1'b0, 31, blk, ce, 0, 1'b0, res);
    chk("rounds31_eq_16", res, ce);

    // Subkey write during a round is ignored, now and afterwards.
    blk2 = $urandom;
    e2   = ref_rc5(1'b0, 4, blk2);
    do_op(1'b0, 4, blk2, e2, 0, 1'b1, res);
    wr_key(40, 16'hFFFF);
    do_op(1'b0, 4, blk2, e2, 0, 1'b0, res);

`ifdef RC5_ABORT_EN
    start_valid = 1'b1; mode = 1'b0; rounds = RW'(10); d_in = blk2;
    step();
    start_valid = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", {start_ready, out_valid, busy}, 3'b100);
    chk("abort_dout", d_out, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_flags", {start_ready, busy}, 2'b10);
    do_op(1'b0, 4, blk2, e2, 0, 1'b0, res);
`endif

    // Reset in the middle of a round sequence.
    start_valid = 1'b1; mode = 1'b0; rounds = RW'(10); d_in = blk;
    step();
    start_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("midreset_flags", {start_ready, out_valid, busy}, 3'b100);
    chk("midreset_dout", d_out, 0);
    rst = 1'b1;
    for (int k = 0; k < NK; k++) skm[k] = '0;
    step();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      step();
    end
    chk("midreset_no_result", seen, 0);
    do_op(1'b0, 1, 32'h0001_0000, 32'h000C_0002, 0, 1'b0, res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc5_core_param.md
# rc5_core_param

Parametrised iterative RC5-W/R/b cipher engine: encrypts or decrypts one 2W-bit block per request at one round per clock. The subkey table is loaded at runtime through a write port rather than held as constants. Request and result use valid/ready handshakes. The block sits between the host register interface (subkey load, request issue) and the result buffer, and replaces the fixed 16-bit, fixed-key engine.

## Interface
- `W`, 16: word width in bits; legal values are 16 and 32. Block width is 2W.
- `MAX_ROUNDS`, 16: largest supported round count. The subkey table depth is 2*MAX_ROUNDS+2.
- `RW`, $clog2(MAX_ROUNDS+1): width of the `rounds` field.
- `AW`, $clog2(2*MAX_ROUNDS+2): subkey address width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `start_valid` in 1: request valid.
- `start_ready` out 1: engine can accept a request (state IDLE).
- `mode` in 1: 0 = encrypt, 1 = decrypt. Sampled on accept.
- `rounds` in RW: round count r. Sampled on accept. Values above MAX_ROUNDS saturate to MAX_ROUNDS.
- `d_in` in 2W: input block. Sampled on accept. A = d_in[W-1:0], B = d_in[2W-1:W].
- `skey_we` in 1: subkey write strobe.
- `skey_addr` in AW: subkey index. Indexes at or above 2*MAX_ROUNDS+2 are ignored.
- `skey_wdata` in W: subkey value.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumer ready.
- `d_out` out 2W: result block {B, A}. Holds its value while `out_valid` is high.
- `busy` out 1: high in every state except IDLE.
- `abort` in 1: exists only with RC5_ABORT_EN.

## Operation
- State machine states: IDLE, ROUND, POSTW, DONE.
- **IDLE → (accept)**
  - Accept occurs when `start_valid` && `start_ready`.
  - Encrypt: A←lo+S[0], B←hi+S[1]; go to ROUND if r>0, otherwise DONE.
  - Decrypt: A←lo, B←hi; round index i←r; go to ROUND if r>0, otherwise POSTW.
- **ROUND, encrypt**
  - i runs 1..r, one round per cycle.
  - A' = rotl(A^B, B) + S[2i]; B' = rotl(B^A', A') + S[2i+1].
  - Go to DONE after i=r.
- **ROUND, decrypt**
  - i runs r..1, one round per cycle.
  - B' = rotr(B − S[2i+1], A) ^ A; A' = rotr(A − S[2i], B') ^ B'.
  - Go to POSTW after i=1.
- **POSTW**: B←B−S[1], A←A−S[0]; go to DONE.
- **DONE**: `out_valid`=1 and `d_out`={B,A}. On `out_ready` go to IDLE.
- Arithmetic and rotation rules:
  - All add/sub is modulo 2^W.
  - Rotate amount is the low $clog2(W) bits of the operand.
  - A rotate amount of 0 is the identity.
- Subkey table:
  - Writes take effect on the next edge, and only in IDLE.
  - `skey_we` in any other state is ignored.
  - A write in the same cycle as an accept is applied; the accepted operation uses the new value from the following cycle on.
- `d_out` is 0 outside DONE.

## Timing
- Reset values:
  - Outputs: `start_ready`=1 (IDLE), `out_valid`=0, `d_out`=0, `busy`=0.
  - Internal: A, B, round counter and every subkey entry = 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced.
- Latency, with accept in cycle k:
  - Encrypt: `out_valid` first high in cycle k+r+1.
  - Decrypt: `out_valid` first high in cycle k+r+2.
- `start_ready` is 0 from cycle k+1 until the cycle after the DONE handshake. There is no back-to-back accept in the handshake cycle.
- Backpressure: DONE holds indefinitely with `d_out` stable.
- `mode`, `rounds` and `d_in` are don't-care after the accept edge.

## Configuration
- With `RC5_ABORT_EN` defined:
  - The `abort` input exists.
  - `abort`=1 in ROUND, POSTW or DONE forces IDLE on the next edge, with `out_valid`=0 and A=B=0.
  - `abort` in IDLE has no effect, and the subkey table is preserved.
- Without the macro: the port is absent, and every accepted operation runs to DONE.

## Test plan
- **Encrypt, 1 round.** W=16, all S=0, mode=0, r=1, d_in=0x0001_0000 → `out_valid` in cycle k+2, `d_out`=0x000C_0002.
- **Decrypt, 1 round.** All S=0, mode=1, r=1, d_in=0x000C_0002 → `out_valid` in cycle k+3, `d_out`=0x0001_0000.
- **Zero rounds.** Write S[0]=0x0005, S[1]=0x0007.
  - Encrypt r=0, d_in=0x0010_0020 → `d_out`=0x0017_0025 in cycle k+1.
  - Decrypt r=0 of 0x0017_0025 → 0x0010_0020.
- **Round trip with backpressure.** Load 34 random subkeys; encrypt r=16 on a random block, then decrypt the result with r=16 → original block. Hold `out_ready`=0 for 5 cycles: `d_out` stable, `start_ready`=0.
- **Write while busy.** Pulse `skey_we` to S[2]=0xFFFF during ROUND → current result unchanged, and a later read-back encrypt still uses the old S[2]. Separately, `rounds`=31 behaves identically to 16.
- **Abort / reset mid-operation.** Under RC5_ABORT_EN, `abort` in round 3 → IDLE next cycle, no `out_valid`. Reset low mid-ROUND → all outputs at their reset values next cycle.
